regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the CPU register file. It shares the single register-file write port between `NUM_REQ` result producers, such as the ALU, the load unit and the CSR unit, using round-robin arbitration. It also keeps a per-register busy scoreboard that gates instruction issue on WAW hazards and flags RAW hazards on the read ports. It sits between the execute/memory units and `register_file`, and drives its `i_we`/`i_waddr`/`i_wdata` directly.

## Interface
Parameters:
- `NUM_REQ`, 3, number of write-back requesters (≥2)
- `NUM_RPORTS`, 2, number of read-address hazard check ports; matches the register file

Ports:
- `i_clk`  in  1  clock, rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_req_valid`  in  [NUM_REQ-1:0]  requester has a result
- `o_req_ready`  out  [NUM_REQ-1:0]  one-hot grant; request is consumed this cycle
- `i_req_addr`  in  regaddr_t [0:NUM_REQ-1]  destination register per requester
- `i_req_data`  in  [`XLEN-1:0] [0:NUM_REQ-1]  result data per requester
- `i_issue_valid`  in  1  decode wants to issue an instruction writing `i_issue_rd`
- `i_issue_rd`  in  regaddr_t  destination of the issuing instruction
- `o_issue_ready`  out  1  issue accepted this cycle
- `i_raddr`  in  regaddr_t [0:NUM_RPORTS-1]  source addresses to check
- `o_raddr_busy`  out  [NUM_RPORTS-1:0]  source has a pending write
- `o_rf_we`, `o_rf_waddr`, `o_rf_wdata`  out  1 / regaddr_t / `XLEN  register file write port

## Operation
- State consists of the round-robin pointer `ptr` (0..NUM_REQ-1) and `busy[NUM_REGS-1:0]`. `busy[0]` is hardwired to 0.
- Arbitration:
  - The winner is the first valid requester scanning `ptr, ptr+1, …` mod NUM_REQ.
  - `o_req_ready[winner]=1`; all other ready bits are 0.
  - If no requester is valid, there is no grant and `ptr` holds.
  - On a grant, `ptr <= (winner+1) mod NUM_REQ`.
- Write port:
  - `o_rf_waddr` and `o_rf_wdata` carry the winner's address and data.
  - `o_rf_we = grant && waddr!=0`.
  - A request to x0 is still granted and consumed, but performs no write and has no scoreboard effect.
- Scoreboard:
  - `o_issue_ready = !busy[i_issue_rd]`. There is no same-cycle bypass from write-back.
  - On an accepted issue with `rd!=0`, `busy[rd] <= 1`. Issue of rd=0 is always ready and sets nothing.
  - On a granted write with `waddr!=0`, `busy[waddr] <= 0`. Clearing a non-busy register is a no-op.
  - Set and clear in the same cycle on different registers both take effect. The same register cannot be both set and cleared in one cycle: a set requires `busy=0` and a clear only matters when `busy=1`. If it occurs anyway, set wins.
- `o_raddr_busy[p] = busy[i_raddr[p]]`, taken from registered state only.
- During `i_rst=1`: all `o_req_ready` are 0, `o_rf_we=0` and `o_issue_ready=0`.

## Timing
- Grant, ready and the `o_rf_*` outputs are combinational from `i_req_valid` and `ptr`, with zero latency.
- The register file captures the write at the next rising edge.
- `busy` updates at that same edge. In the following cycle the read port returns the new value and `o_raddr_busy` is 0.
- A busy bit set by an issue is visible from the cycle after issue.
- Requesters hold valid, address and data until they see ready. They must not depend on ready to raise valid.
- Reset values: `ptr=0`, `busy=0`.
- Reset mid-operation discards pending requests and in-flight scoreboard state. The pipeline flushes alongside.
- Sustained throughput is one write per cycle. With all requesters valid, each is granted at least once every NUM_REQ cycles.

## Structure
- Shared package `cpu_pkg`: `typedef logic [$clog2(`NUM_REGS)-1:0] regaddr_t;`. `XLEN` and `NUM_REGS` continue to come from `defs.svh`.
- Sub-module `rr_arbiter #(N)`: inputs `i_clk`, `i_rst`, `i_req[N]`; outputs one-hot `o_gnt[N]` and `o_gnt_idx`. It owns `ptr` and is reusable by the memory-port arbiter.
- The address/data select reuses the existing `mux` indexed by `o_gnt_idx`.
- The set/clear one-hot vectors reuse the existing `dec`.

## Test plan
- Reset: hold `i_rst=1` for 2 cycles with all requesters valid and `i_issue_valid=1`. Required: `o_req_ready=0`, `o_rf_we=0`, `o_issue_ready=0`. After release, the first grant goes to req0.
- Round-robin: all 3 requesters valid continuously with addresses 5, 6, 7. Required: grant sequence 0,1,2,0,1; `o_rf_waddr` sequence 5,6,7,5,6; `o_rf_we=1` every cycle.
- Hazards on one register, cycle by cycle:
  - Cycle 0: issue rd=9. Required: `o_issue_ready=1`.
  - Cycle 1: `i_raddr[0]=9`. Required: `o_raddr_busy[0]=1`.
  - Cycle 2: issue rd=9 again. Required: `o_issue_ready=0`.
  - Cycle 3: req1 writes 9 with data 0xDEADBEEF.
  - Cycle 4: required: `o_raddr_busy[0]=0`, `o_issue_ready=1`, and register 9 reads 0xDEADBEEF.
- x0 handling: issue rd=0, then req2 writes x0. Required: `o_issue_ready=1`; no busy bit is set; `o_req_ready[2]=1` with `o_rf_we=0`.
- Simultaneous events: with `busy[4]=1`, issue rd=3 in the same cycle that req0 writes 4. Required next cycle: `busy[3]=1`, `busy[4]=0`.
- Reset mid-operation: with `busy[3]=1`, `ptr=2` and req1 valid, pulse `i_rst` for 1 cycle. Required: `busy` is all zero; the next grant with req0 and req1 both valid goes to req0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared CPU types: register address type sized from NUM_REGS.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

package cpu_pkg;
    localparam int c_reg_aw = $clog2(`NUM_REGS);
    typedef logic [c_reg_aw-1:0] regaddr_t;
endpackage
`default_nettype wire

// File: rtl/dec.sv
`default_nettype none
// ============================================================================
// Module  : dec
// Brief   : Enabled binary-to-one-hot decoder.
// Revision: 1.0 - initial release
// ============================================================================
module dec #(
    parameter int N  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic [IW-1:0] i_idx,
    input  logic          i_en,
    output logic [N-1:0]  o_onehot
);
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mux.sv
`default_nettype none
// ============================================================================
// Module  : mux
// Brief   : N-input W-bit multiplexer selected by binary index.
// Revision: 1.0 - initial release
// ============================================================================
module mux #(
    parameter int N  = 2,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0][W-1:0] i_data,
    input  logic [SW-1:0]       i_sel,
    output logic [W-1:0]        o_data
);
    assign o_data = i_data[i_sel];
endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin arbiter; scan starts at ptr, ptr moves past winner.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N-1:0]         i_req,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_gnt_idx
);
    localparam int c_iw = $clog2(N);
    localparam int c_sw = c_iw + 1;

    logic [c_iw-1:0] r_ptr;
    logic [c_iw-1:0] w_idx;
    logic            w_any;

    always_comb begin
        logic [c_sw-1:0] w_sum;
        logic [c_iw-1:0] w_cand;
        w_any  = 1'b0;
        w_idx  = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + c_sw'(k);
            if (w_sum >= c_sw'(N)) begin
                w_sum = w_sum - c_sw'(N);
            end
            w_cand = w_sum[c_iw-1:0];
            if (!w_any && i_req[w_cand]) begin
                w_any = 1'b1;
                w_idx = w_cand;
            end
        end
    end

    // No grant is issued while reset is asserted.
    always_comb begin
        o_gnt = '0;
        if (w_any && !i_rst) begin
            o_gnt[w_idx] = 1'b1;
        end
    end

    assign o_gnt_idx = w_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_idx == c_iw'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Round-robin write-back arbiter with per-register busy scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int NUM_RPORTS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  regaddr_t              i_req_addr [0:NUM_REQ-1],
    input  logic [`XLEN-1:0]      i_req_data [0:NUM_REQ-1],
    input  logic                  i_issue_valid,
    input  regaddr_t              i_issue_rd,
    output logic                  o_issue_ready,
    input  regaddr_t              i_raddr [0:NUM_RPORTS-1],
    output logic [NUM_RPORTS-1:0] o_raddr_busy,
    output logic                  o_rf_we,
    output regaddr_t              o_rf_waddr,
    output logic [`XLEN-1:0]      o_rf_wdata
);
    localparam int c_gw = $clog2(NUM_REQ);
    localparam int c_aw = $bits(regaddr_t);
    localparam int c_nr = `NUM_REGS;

    logic [NUM_REQ-1:0]              w_gnt;
    logic [c_gw-1:0]                 w_gnt_idx;
    logic                            w_grant;
    logic [NUM_REQ-1:0][c_aw-1:0]    w_addr_flat;
    logic [NUM_REQ-1:0][`XLEN-1:0]   w_data_flat;
    logic [c_aw-1:0]                 w_waddr;
    logic                            w_issue_fire;
    logic [c_nr-1:0]                 w_set;
    logic [c_nr-1:0]                 w_clr;
    logic [c_nr-1:0]                 w_busy_nxt;
    logic [c_nr-1:0]                 r_busy;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req_valid),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
            assign w_addr_flat[g] = i_req_addr[g];
            assign w_data_flat[g] = i_req_data[g];
        end
    endgenerate

    mux #(.N(NUM_REQ), .W(c_aw)) u_addr_mux (
        .i_data (w_addr_flat),
        .i_sel  (w_gnt_idx),
        .o_data (w_waddr)
    );

    mux #(.N(NUM_REQ), .W(`XLEN)) u_data_mux (
        .i_data (w_data_flat),
        .i_sel  (w_gnt_idx),
        .o_data (o_rf_wdata)
    );

    assign w_grant     = |w_gnt;
    assign o_req_ready = w_gnt;
    assign o_rf_waddr  = w_waddr;
    // x0 writes are consumed but never reach the register file or scoreboard.
    assign o_rf_we     = w_grant && (w_waddr != '0);

    assign o_issue_ready = !i_rst && !r_busy[i_issue_rd];
    assign w_issue_fire  = i_issue_valid && o_issue_ready && (i_issue_rd != '0);

    dec #(.N(c_nr)) u_set_dec (
        .i_idx    (i_issue_rd),
        .i_en     (w_issue_fire),
        .o_onehot (w_set)
    );

    dec #(.N(c_nr)) u_clr_dec (
        .i_idx    (w_waddr),
        .i_en     (o_rf_we),
        .o_onehot (w_clr)
    );

    // Set is applied after clear so a same-register collision leaves it busy.
    always_comb begin
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    generate
        for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
            assign o_raddr_busy[p] = r_busy[i_raddr[p]];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Brief   : Directed plus random bench against a behavioural arbiter model.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NUM_REGS
`define NUM_REGS 32
`endif
module tb_regfile_wb_arbiter;
    import cpu_pkg::*;

    localparam int NREQ  = 3;
    localparam int NRP   = 2;
    localparam int XL    = `XLEN;
    localparam int NREGS = `NUM_REGS;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    regaddr_t        req_addr [0:NREQ-1];
    logic [XL-1:0]   req_data [0:NREQ-1];
    logic            issue_valid;
    logic            issue_ready;
    regaddr_t        issue_rd;
    regaddr_t        raddr [0:NRP-1];
    logic [NRP-1:0]  raddr_busy;
    logic            rf_we;
    regaddr_t        rf_waddr;
    logic [XL-1:0]   rf_wdata;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_REQ(NREQ), .NUM_RPORTS(NRP)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_addr    (req_addr),
        .i_req_data    (req_data),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .o_issue_ready (issue_ready),
        .i_raddr       (raddr),
        .o_raddr_busy  (raddr_busy),
        .o_rf_we       (rf_we),
        .o_rf_waddr    (rf_waddr),
        .o_rf_wdata    (rf_wdata)
    );

    int            m_ptr = 0;
    bit            m_busy [0:NREGS-1];
    logic [XL-1:0] rf_mirror [0:NREGS-1];
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int winner(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model state advances on each rising edge.
    always @(posedge clk) begin
        int w;
        bit iss_ok;
        if (rst) begin
            m_ptr <= 0;
            foreach (m_busy[i]) m_busy[i] <= 1'b0;
        end else begin
            w = winner(req_valid, m_ptr);
            iss_ok = issue_valid && !m_busy[issue_rd];
            if (w >= 0) begin
                m_ptr <= (w + 1) % NREQ;
                if (req_addr[w] != 0) m_busy[req_addr[w]] <= 1'b0;
            end
            if (iss_ok && issue_rd != 0) m_busy[issue_rd] <= 1'b1;
        end
        if (rf_we) rf_mirror[rf_waddr] <= rf_wdata;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        int w;
        logic [NREQ-1:0] eg;
        w = rst ? -1 : winner(req_valid, m_ptr);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        check("mdl_ready", 32'(req_ready), 32'(eg));
        if (w >= 0) begin
            check("mdl_we", 32'(rf_we), 32'(req_addr[w] != 0));
            check("mdl_waddr", 32'(rf_waddr), 32'(req_addr[w]));
            check("mdl_wdata", rf_wdata, req_data[w]);
        end else begin
            check("mdl_we_idle", 32'(rf_we), 32'd0);
        end
        check("mdl_issue_ready", 32'(issue_ready), 32'(!rst && !m_busy[issue_rd]));
        for (int p = 0; p < NRP; p++) begin
            check("mdl_raddr_busy", 32'(raddr_busy[p]), 32'(m_busy[raddr[p]]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_gnt_exp  [5] = '{1, 2, 4, 1, 2};
    int rr_addr_exp [5] = '{5, 6, 7, 5, 6};
    logic [NREQ-1:0] was_gnt;

    initial begin
        rst = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i] = regaddr_t'(5 + i);
            req_data[i] = 32'h100 + 32'(i);
        end
        issue_valid = 1'b1;
        issue_rd = regaddr_t'(1);
        raddr[0] = '0;
        raddr[1] = '0;

        repeat (2) begin
            @(negedge clk);
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_we", 32'(rf_we), 32'd0);
            check("rst_issue_ready", 32'(issue_ready), 32'd0);
            tick();
        end
        rst = 1'b0;
        issue_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rr_gnt", 32'(req_ready), rr_gnt_exp[i]);
            check("rr_waddr", 32'(rf_waddr), rr_addr_exp[i]);
            check("rr_we", 32'(rf_we), 32'd1);
            tick();
        end

        req_valid = '0;
        issue_valid = 1'b1;
        issue_rd = regaddr_t'(9);
        @(negedge clk);
        check("haz_issue0", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        raddr[0] = regaddr_t'(9);
        @(negedge clk);
        check("haz_busy_set", 32'(raddr_busy[0]), 32'd1);
        tick();
        issue_valid = 1'b1;
        @(negedge clk);
        check("haz_issue_block", 32'(issue_ready), 32'd0);
        tick();
        issue_valid = 1'b0;
        req_valid = 3'b010;
        req_addr[1] = regaddr_t'(9);
        req_data[1] = 32'hDEADBEEF;
        @(negedge clk);
        check("haz_wb_gnt", 32'(req_ready), 32'b010);
        check("haz_wb_we", 32'(rf_we), 32'd1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("haz_busy_clr", 32'(raddr_busy[0]), 32'd0);
        check("haz_issue_again", 32'(issue_ready), 32'd1);
        check("haz_rf_data", rf_mirror[9], 32'hDEADBEEF);
        tick();

        issue_valid = 1'b1;
        issue_rd = '0;
        @(negedge clk);
        check("x0_issue", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        raddr[0] = '0;
        req_valid = 3'b100;
        req_addr[2] = '0;
        @(negedge clk);
        check("x0_gnt", 32'(req_ready), 32'b100);
        check("x0_we", 32'(rf_we), 32'd0);
        check("x0_busy", 32'(raddr_busy[0]), 32'd0);
        tick();

        req_valid = '0;
        issue_valid = 1'b1;
        issue_rd = regaddr_t'(4);
        @(negedge clk);
        check("sim_issue4", 32'(issue_ready), 32'd1);
        tick();
        issue_rd = regaddr_t'(3);
        req_valid = 3'b001;
        req_addr[0] = regaddr_t'(4);
        @(negedge clk);
        check("sim_gnt", 32'(req_ready), 32'b001);
        check("sim_issue3", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        req_valid = '0;
        raddr[0] = regaddr_t'(3);
        raddr[1] = regaddr_t'(4);
        @(negedge clk);
        check("sim_busy", 32'(raddr_busy), 32'b01);
        tick();

        req_valid = 3'b010;
        req_addr[1] = regaddr_t'(10);
        @(negedge clk);
        check("mid_pre_gnt", 32'(req_ready), 32'b010);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_busy_before", 32'(raddr_busy[0]), 32'd1);
        tick();
        rst = 1'b0;
        req_valid = 3'b011;
        req_addr[0] = regaddr_t'(11);
        @(negedge clk);
        check("mid_busy_cleared", 32'(raddr_busy), 32'd0);
        check("mid_gnt", 32'(req_ready), 32'b001);
        tick();

        req_valid = '0;
        was_gnt = '0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || was_gnt[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_addr[i]  = regaddr_t'($urandom_range(0, 15));
                    req_data[i]  = $urandom;
                end
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = regaddr_t'($urandom_range(0, 15));
            raddr[0] = regaddr_t'($urandom_range(0, 15));
            raddr[1] = regaddr_t'($urandom_range(0, 15));
            @(negedge clk);
            was_gnt = req_ready;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
